// File: rtl/jtframe_quad_enc_if.sv
// Delta-pair handshake between a movement source and jtframe_quad_enc.
// The master presents signed X/Y deltas with in_valid; the slave answers with in_ready.
interface jtframe_quad_enc_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] delta_x;
  logic [DW-1:0] delta_y;

  modport master (
    output in_valid,
    output delta_x,
    output delta_y,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  delta_x,
    input  delta_y,
    output in_ready
  );
endinterface

// File: rtl/jtframe_quad_enc.sv
// Quadrature encoder transmitter: turns buffered signed X/Y deltas into Gray-coded
// dial pulse trains, one step per axis every DIV clocks, with accept back-pressure.
module jtframe_quad_enc #(
  parameter int DW  = 8,
  parameter int AW  = 12,
  parameter int DIV = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  jtframe_quad_enc_if.slave       bus,
  output logic [1:0]              o_dial_x,
  output logic [1:0]              o_dial_y,
  output logic                    o_idle
);

  localparam int CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int LIM_INT = (1 << (AW - 1)) - 1 - (1 << (DW - 1));
  localparam logic signed [AW-1:0] LIM_P = AW'(LIM_INT);
  localparam logic signed [AW-1:0] LIM_N = AW'(-LIM_INT);
  localparam logic [CW-1:0]        CNT_TOP = CW'(DIV - 1);

  // One Gray step forward (00,01,11,10) or backward along the same cycle.
  function automatic logic [1:0] gray_step(input logic [1:0] g, input logic fwd);
    logic [1:0] r;
    case (g)
      2'b00:   r = fwd ? 2'b01 : 2'b10;
      2'b01:   r = fwd ? 2'b11 : 2'b00;
      2'b11:   r = fwd ? 2'b10 : 2'b01;
      2'b10:   r = fwd ? 2'b00 : 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Amount an accumulator moves toward zero when a step is emitted.
  function automatic logic signed [AW-1:0] acc_sign(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    if (a[AW-1]) begin
      r = {AW{1'b1}};
    end else if (a != '0) begin
      r = {{(AW-1){1'b0}}, 1'b1};
    end else begin
      r = '0;
    end
    return r;
  endfunction

  logic [CW-1:0]        r_cnt;
  logic signed [AW-1:0] r_acc_x;
  logic signed [AW-1:0] r_acc_y;
  logic [1:0]           r_dial_x;
  logic [1:0]           r_dial_y;

  logic                 w_tick;
  logic                 w_ready;
  logic                 w_accept;
  logic signed [AW-1:0] w_dx_ext;
  logic signed [AW-1:0] w_dy_ext;
  logic signed [AW-1:0] w_sx;
  logic signed [AW-1:0] w_sy;
  logic signed [AW-1:0] w_acc_x_nx;
  logic signed [AW-1:0] w_acc_y_nx;
  logic [1:0]           w_dial_x_nx;
  logic [1:0]           w_dial_y_nx;
  logic [CW-1:0]        w_cnt_nx;

  assign w_tick   = (r_cnt == CNT_TOP);
  // Limits leave headroom for one full-scale delta, so accepted deltas cannot overflow.
  assign w_ready  = !i_clr
                    && (r_acc_x <= LIM_P) && (r_acc_x >= LIM_N)
                    && (r_acc_y <= LIM_P) && (r_acc_y >= LIM_N);
  assign w_accept = bus.in_valid && w_ready;
  assign w_dx_ext = {{(AW-DW){bus.delta_x[DW-1]}}, bus.delta_x};
  assign w_dy_ext = {{(AW-DW){bus.delta_y[DW-1]}}, bus.delta_y};
  assign w_sx     = acc_sign(r_acc_x);
  assign w_sy     = acc_sign(r_acc_y);

  assign bus.in_ready = w_ready;
  assign o_dial_x     = r_dial_x;
  assign o_dial_y     = r_dial_y;
  assign o_idle       = (r_acc_x == '0) && (r_acc_y == '0);

  // Next divider count: free-running wrap at DIV-1.
  always_comb begin
    w_cnt_nx = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    if (w_tick) begin
      w_cnt_nx = '0;
    end else begin
      w_cnt_nx = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Next accumulators and phases; clr wins over both accept and tick.
  always_comb begin
    w_acc_x_nx  = r_acc_x;
    w_acc_y_nx  = r_acc_y;
    w_dial_x_nx = r_dial_x;
    w_dial_y_nx = r_dial_y;
    if (i_clr) begin
      w_acc_x_nx = '0;
      w_acc_y_nx = '0;
    end else begin
      w_acc_x_nx = r_acc_x + (w_accept ? w_dx_ext : '0) - (w_tick ? w_sx : '0);
      w_acc_y_nx = r_acc_y + (w_accept ? w_dy_ext : '0) - (w_tick ? w_sy : '0);
      if (w_tick && (r_acc_x != '0)) begin
        w_dial_x_nx = gray_step(r_dial_x, !r_acc_x[AW-1]);
      end else begin
        w_dial_x_nx = r_dial_x;
      end
      if (w_tick && (r_acc_y != '0)) begin
        w_dial_y_nx = gray_step(r_dial_y, !r_acc_y[AW-1]);
      end else begin
        w_dial_y_nx = r_dial_y;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc_x  <= '0;
      r_acc_y  <= '0;
      r_dial_x <= 2'b00;
      r_dial_y <= 2'b00;
    end else begin
      r_cnt    <= w_cnt_nx;
      r_acc_x  <= w_acc_x_nx;
      r_acc_y  <= w_acc_y_nx;
      r_dial_x <= w_dial_x_nx;
      r_dial_y <= w_dial_y_nx;
    end
  end

endmodule

// File: doc/jtframe_quad_enc.md
Name: jtframe_quad_enc

Overview:
- Quadrature encoder transmitter: converts signed relative movement deltas (mouse, analog stick, or network spinner packets) into 2-bit Gray-coded dial_x/dial_y pulse trains.
- Output is paced at a programmable step rate.
- Drives the x_in/y_in inputs of the jt4701 counter or any game-side quadrature decoder.
- Complements jtframe_dial: this block takes buffered counted deltas with a valid/ready handshake and back-pressure, instead of raw spinner edges.

Parameters:
- DW, 8: width of the signed delta inputs.
- AW, 12: width of each signed per-axis pending-step accumulator. AW > DW+1.
- DIV, 16: clock cycles per quadrature step. Legal range 2..65535.

Ports:
- rst  in  1  synchronous reset, active-high.
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  discard all pending steps; quadrature phase is kept.
- in_valid  in  1  delta pair valid.
- in_ready  out  1  block can accept a delta pair this cycle.
- delta_x  in  DW  signed X movement, two's complement; positive = right.
- delta_y  in  DW  signed Y movement, two's complement; positive = down.
- dial_x  out  2  X quadrature pair {B,A}.
- dial_y  out  2  Y quadrature pair {B,A}.
- idle  out  1  high when both accumulators are zero.

Behaviour:
- Reset values:
  - acc_x = acc_y = 0.
  - dial_x = dial_y = 2'b00.
  - Step divider counter = 0.
  - in_ready = 1, idle = 1.
- Transfer: a delta pair is accepted on any cycle where in_valid && in_ready.
  - Each delta is sign-extended and added to its axis accumulator.
  - The result is visible in the registers the next cycle.
- Back-pressure:
  - in_ready is combinational.
  - in_ready = !clr && |acc_x| <= LIM && |acc_y| <= LIM, with LIM = 2^(AW-1)-1 - 2^(DW-1).
  - An accepted delta therefore never overflows. No saturation logic is needed.
- Divider:
  - Free-running counter 0..DIV-1. tick = (cnt == DIV-1).
  - First tick occurs DIV cycles after reset release.
  - Ticks continue whether or not the block is idle.
- On a tick, each axis is evaluated independently from its registered accumulator value:
  - acc > 0: phase advances one Gray step forward (00→01→11→10→00); acc decrements by 1.
  - acc < 0: phase steps backward (00→10→11→01→00); acc increments by 1.
  - acc == 0: no change.
- dial outputs are registered. They change on the cycle after the tick, and only one bit changes per step.
- Accept and tick in the same cycle: acc_next = acc + delta − sign(acc). Both effects apply.
- A delta that reverses sign while steps are still pending simply nets against the accumulator. Any steps already emitted are not retracted.
- clr:
  - acc_x and acc_y become 0 on the next cycle.
  - Phase and divider are untouched.
  - in_ready is low while clr is high, so no delta is lost silently.
  - clr has priority over a tick in the same cycle: no step is emitted.
- idle = (acc_x == 0) && (acc_y == 0), registered-value based.
- Reset mid-burst: all pending steps are dropped and both outputs return to 00 the cycle after rst is sampled high.

Test Plan:
- DIV=4, reset, then accept delta_x=+3, delta_y=0:
  - dial_x goes 00→01→11→10, one step every 4 cycles, starting after the first tick following acceptance.
  - dial_y stays 00.
  - idle rises after the third step.
- From dial_x=10 with acc 0, accept delta_x=−2:
  - dial_x goes 10→11→01.
  - Connected jt4701 X count returns net +1.
- Simultaneous axes: delta_x=+5, delta_y=−5, DIV=4:
  - Both axes step on the same ticks.
  - Final dial_x=01 and dial_y=10, starting from 00.
- Back-pressure: DIV=1024, AW=12, DW=8; push delta_x=+127 on consecutive cycles:
  - in_ready stays high through 15 acceptances (acc=1905).
  - After the 16th acceptance (acc=2032 > 1919), in_ready drops.
  - in_ready recovers only once acc ≤ 1919.
- Accept on a tick cycle: acc_x=1, accept +1 exactly on the tick → acc_x=1 next cycle and one step emitted.
- Accept −1 on a tick with acc_x=1 → acc_x=−1 next cycle, one forward step emitted.
- clr:
  - Assert clr with acc_x=50 → acc_x=0 next cycle, phase held, in_ready low while clr is high.
  - Assert rst mid-burst → dial_x=dial_y=00 and idle=1 next cycle.
